sobel_stream_edge: RTL
======================

SOBEL_STREAM_EDGE -- requirements
Module: sobel_stream_edge

Interface
REQ-001 Parameter PIX_W, default 8, pixel and output width in bits.
REQ-002 Parameter LINE_W, default 640, pixels per image line; legal range 8..4096.
REQ-003 clock  input  1  single rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 pix_in  input  PIX_W  unsigned input pixel, raster order.
REQ-006 pix_valid  input  1  pix_in is valid this cycle; gaps of any length are allowed.
REQ-007 sof  input  1  start of frame; sampled only when pix_valid=1.
REQ-008 mode  input  1  kernel select, 0 = 3x3 Sobel, 1 = 5x5 Sobel; sampled only on an accepted sof pixel.
REQ-009 thresh  input  PIX_W  binarisation threshold; used only with SOBEL_THRESH_EN.
REQ-010 edge_out  output  PIX_W  edge magnitude or binary edge value.
REQ-011 edge_valid  output  1  edge_out is valid this cycle.
REQ-012 edge_sof  output  1  edge_out belongs to frame pixel (0,0).

Function
REQ-013 An accepted pixel (pix_valid=1) shall be written to the line buffers and shall advance the col/row counters; nothing changes when pix_valid=0.
REQ-014 col shall wrap from LINE_W-1 to 0 and increment row; row shall saturate at 4.
REQ-015 An accepted pixel with sof=1 shall be pixel (0,0); col and row restart there and mode is latched.
REQ-016 Four line buffers of LINE_W x PIX_W shall supply a KxK window (K = 3 or 5), with its bottom-right corner at the current pixel.
REQ-017 3x3 mode: Gx = [-1 0 1; -2 0 2; -1 0 1]; Gy = transpose, positive on the top row.
REQ-018 5x5 mode: Gx columns weighted [-1 -2 0 2 1]; rows weighted [1 4 6 4 1]; Gy = transpose, positive on the top row.
REQ-019 Gx and Gy shall be signed, PIX_W+7 bits wide, with no overflow.
REQ-020 mag = |Gx| + |Gy|, saturated to 2^PIX_W-1.
REQ-021 If row < K-1 or col < K-1, mag shall be forced to 0.
REQ-022 edge_valid shall follow each accepted pixel by exactly 4 cycles, one output per input, in order; the pipeline advances every cycle.
REQ-023 edge_sof shall follow sof & pix_valid with the same 4-cycle latency.
REQ-024 When edge_valid=0, edge_out shall hold 0.
REQ-025 A mode change without sof shall be ignored until the next accepted sof.

Reset
REQ-026 Reset shall clear col, row, latched mode (to 0), all pipeline valid/sof tags, edge_out, edge_valid and edge_sof on the next edge.
REQ-027 Line buffer contents shall not be cleared; stale data is masked by REQ-021.
REQ-028 Reset mid-frame shall drop in-flight outputs; the next accepted pixel shall be (0,0) regardless of sof.

Configuration
REQ-029 With SOBEL_THRESH_EN defined: edge_out = 2^PIX_W-1 if mag >= thresh, else 0.
REQ-030 Without SOBEL_THRESH_EN: edge_out = mag, thresh is ignored, and no compare logic is built.

Verification
REQ-031 LINE_W=8, mode=0, a flat 8x8 frame of 100 -> all edge_out=0; edge_valid exactly 4 cycles after each pix_valid; edge_sof once.
REQ-032 LINE_W=8, mode=0, cols 0-3=0 and cols 4-7=255, macro off -> rows>=2: edge_out=255 (Gx=1020, saturated) at cols 4,5, and 0 elsewhere.
REQ-033 The same step with mode=1 latched at sof -> rows>=4: edge_out=255 at cols 4-7, and 0 elsewhere including rows 0-3.
REQ-034 Ramp pixel=col, mode=0 -> edge_out=8 at rows>=2, cols>=2 with the macro off; with the macro on, thresh=8 gives 255 and thresh=9 gives 0.
REQ-035 Repeat REQ-032 with pix_valid alternating 1/0 and random gaps -> an edge_out sequence identical to the continuous run.
REQ-036 Reset for 1 cycle at row 3, col 5 -> edge_valid=0 next cycle; the following 2 rows of outputs are 0 (border); mode change without sof is ignored.

Source files
------------

// File: rtl/sobel_stream_edge.sv
// Streaming Sobel edge detector: 3x3 or 5x5 kernel chosen per frame, 4-cycle latency, one output per accepted pixel.
// Define SOBEL_THRESH_EN to binarise the magnitude against thresh (full scale if mag >= thresh, else 0).
module sobel_stream_edge #(
  parameter int PIX_W  = 8,
  parameter int LINE_W = 640
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  input  logic             sof,
  input  logic             mode,
  input  logic [PIX_W-1:0] thresh,
  output logic [PIX_W-1:0] edge_out,
  output logic             edge_valid,
  output logic             edge_sof
);
  localparam int CW     = $clog2(LINE_W);
  localparam int GW     = PIX_W + 7;
  localparam int STAGES = 4;
  localparam logic [PIX_W-1:0] PMAX = '1;
  typedef logic signed [GW-1:0] coef_t;

  // Horizontal derivative weights; index 0 is the leftmost window column.
  function automatic int col_wt(input logic m, input int i);
    int w;
    w = 0;
    if (m) begin
      case (i)
        0: w = -1;
        1: w = -2;
        3: w = 2;
        4: w = 1;
        default: w = 0;
      endcase
    end else begin
      case (i)
        2: w = -1;
        4: w = 1;
        default: w = 0;
      endcase
    end
    return w;
  endfunction

  function automatic int row_wt(input logic m, input int i);
    int w;
    w = 0;
    if (m) begin
      case (i)
        0, 4: w = 1;
        1, 3: w = 4;
        2: w = 6;
        default: w = 0;
      endcase
    end else begin
      case (i)
        2, 4: w = 1;
        3: w = 2;
        default: w = 0;
      endcase
    end
    return w;
  endfunction

  logic              acc, mode_q, cur_mode, border;
  logic [CW-1:0]     col, cur_col;
  logic [2:0]        row, cur_row;
  logic [STAGES:1]   vld_pipe, sof_pipe;
  logic              md1, bord1, bord2;
  logic [PIX_W-1:0]  lb [4][LINE_W];
  logic [PIX_W-1:0]  win [5][5];
  logic [PIX_W-1:0]  col_in [5];
  coef_t             gx_c, gy_c, gx, gy, px;
  logic [GW:0]       ax, ay, sum;
  logic [PIX_W-1:0]  sat, mag, out_c;

  assign acc      = pix_valid & ~reset;
  assign cur_col  = sof ? '0 : col;
  assign cur_row  = sof ? '0 : row;
  assign cur_mode = sof ? mode : mode_q;
  // row saturates at 4, so row < 4 still distinguishes the 5x5 top border
  assign border   = cur_mode ? (cur_row < 3'd4 || cur_col < CW'(4))
                             : (cur_row < 3'd2 || cur_col < CW'(2));

  always_ff @(posedge clock) begin
    if (reset) begin
      col    <= '0;
      row    <= '0;
      mode_q <= 1'b0;
    end else if (pix_valid) begin
      mode_q <= cur_mode;
      if (cur_col == CW'(LINE_W - 1)) begin
        col <= '0;
        row <= (cur_row == 3'd4) ? 3'd4 : cur_row + 3'd1;
      end else begin
        col <= cur_col + 1'b1;
        row <= cur_row;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_pipe <= '0;
      sof_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], pix_valid};
      sof_pipe <= {sof_pipe[STAGES-1:1], pix_valid & sof};
    end
  end

  // Column entering the window: lb[3] is the oldest line (top row)
  always_comb begin
    col_in[4] = pix_in;
    for (int k = 0; k < 4; k++) col_in[3-k] = lb[k][cur_col];
  end

  always_comb begin
    gx_c = '0;
    gy_c = '0;
    px   = '0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        px   = coef_t'({7'b0, win[r][c]});
        gx_c = gx_c + px * coef_t'(col_wt(md1, c) * row_wt(md1, r));
        gy_c = gy_c - px * coef_t'(col_wt(md1, r) * row_wt(md1, c));
      end
    end
  end

  always_comb begin
    ax  = {1'b0, gx[GW-1] ? -gx : gx};
    ay  = {1'b0, gy[GW-1] ? -gy : gy};
    sum = ax + ay;
    sat = (sum > {{(GW+1-PIX_W){1'b0}}, PMAX}) ? PMAX : sum[PIX_W-1:0];
  end

  // Datapath registers carry no reset; the valid tags alone qualify them.
  always_ff @(posedge clock) begin
    if (acc) begin
      lb[0][cur_col] <= pix_in;
      for (int k = 1; k < 4; k++) lb[k][cur_col] <= lb[k-1][cur_col];
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 4; c++) win[r][c] <= win[r][c+1];
        win[r][4] <= col_in[r];
      end
    end
    md1   <= cur_mode;
    bord1 <= border;
    gx    <= gx_c;
    gy    <= gy_c;
    bord2 <= bord1;
    mag   <= bord2 ? '0 : sat;
  end

`ifdef SOBEL_THRESH_EN
  assign out_c = (mag >= thresh) ? PMAX : '0;
`else
  logic unused_thresh;
  assign unused_thresh = ^thresh;
  assign out_c = mag;
`endif

  always_ff @(posedge clock) begin
    if (reset) edge_out <= '0;
    else       edge_out <= vld_pipe[STAGES-1] ? out_c : '0;
  end

  assign edge_valid = vld_pipe[STAGES];
  assign edge_sof   = sof_pipe[STAGES];
endmodule
